nios_system_rleds_pwm: RTL and testbench

- Downstream stage of the red-LED PIO: consumes its 18-bit `out_port` pattern and drives the physical LED pins.
- Adds global brightness via PWM and per-LED blink, configured by the Nios II over its own Avalon-MM slave.
- With enable clear, the pattern passes through unchanged, registered.

---
 rtl/nios_system_rleds_pwm.sv | 126 ++++++++++++
 tb/tb_nios_system_rleds_pwm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_rleds_pwm.sv
// Red-LED output stage: registered pass-through of the PIO pattern with
// global PWM brightness and per-LED blink, configured over Avalon-MM.
module nios_system_rleds_pwm #(
   parameter int          LED_WIDTH   = 18,
   parameter int          PWM_BITS    = 8,
   parameter int          DUTY_RESET  = 255,
   parameter logic [15:0] BLINK_RESET = 16'h00FF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [2:0]           address,
   input  logic                 chipselect,
   input  logic                 write_n,
   input  logic [31:0]          writedata,
   output logic [31:0]          readdata,
   input  logic [LED_WIDTH-1:0] led_in,
   output logic [LED_WIDTH-1:0] led_out
);

   logic                 enable;
   logic                 blink_en;
   logic [PWM_BITS-1:0]  duty;
   logic [PWM_BITS-1:0]  duty_active;
   logic [15:0]          prescale;
   logic [15:0]          blink_half;
   logic [LED_WIDTH-1:0] blink_mask;
   logic [15:0]          pre_cnt;
   logic [PWM_BITS-1:0]  pwm_cnt;
   logic [15:0]          blink_cnt;
   logic                 blink_phase;

   logic wr, wr_ctrl, wr_duty, wr_pre, wr_half, wr_mask;
   logic en_rise, pre_hit, tick, pstart, pwm_on;
   logic [LED_WIDTH-1:0] blank;
   logic unused_wd;

   assign unused_wd = ^writedata;

   assign wr      = chipselect & ~write_n;
   assign wr_ctrl = wr && (address == 3'd0);
   assign wr_duty = wr && (address == 3'd1);
   assign wr_pre  = wr && (address == 3'd2);
   assign wr_half = wr && (address == 3'd3);
   assign wr_mask = wr && (address == 3'd5);

   assign en_rise = wr_ctrl && writedata[0] && !enable;
   assign pre_hit = (pre_cnt == prescale);
   // A prescale write restarts the divider and suppresses this cycle's tick
   assign tick    = enable && pre_hit && !wr_pre;
   assign pstart  = tick && (pwm_cnt == {PWM_BITS{1'b1}});
   assign pwm_on  = (pwm_cnt < duty_active);
   assign blank   = blink_mask & {LED_WIDTH{blink_en & blink_phase}};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         enable      <= 1'b0;
         blink_en    <= 1'b0;
         duty        <= PWM_BITS'(DUTY_RESET);
         duty_active <= PWM_BITS'(DUTY_RESET);
         prescale    <= '0;
         blink_half  <= BLINK_RESET;
         blink_mask  <= '0;
         pre_cnt     <= '0;
         pwm_cnt     <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         led_out     <= '0;
      end else begin
         if (wr_ctrl) begin
            enable   <= writedata[0];
            blink_en <= writedata[1];
         end
         if (wr_duty) duty <= writedata[PWM_BITS-1:0];
         if (wr_pre)  prescale <= writedata[15:0];
         if (wr_half) blink_half <= writedata[15:0];
         if (wr_mask) blink_mask <= writedata[LED_WIDTH-1:0];

         if (en_rise) begin
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            duty_active <= duty;
         end else begin
            if (wr_pre || (enable && pre_hit))
               pre_cnt <= '0;
            else if (enable)
               pre_cnt <= pre_cnt + 16'd1;
            if (tick)
               pwm_cnt <= pwm_cnt + 1'b1;
            // Duty shadow and blink timebase only move at period boundaries
            if (pstart) begin
               duty_active <= duty;
               if (blink_cnt == blink_half) begin
                  blink_cnt   <= '0;
                  blink_phase <= ~blink_phase;
               end else begin
                  blink_cnt <= blink_cnt + 16'd1;
               end
            end
         end

         if (enable)
            led_out <= led_in & {LED_WIDTH{pwm_on}} & ~blank;
         else
            led_out <= led_in;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         3'd0: readdata[1:0] = {blink_en, enable};
         3'd1: readdata[PWM_BITS-1:0] = duty;
         3'd2: readdata[15:0] = prescale;
         3'd3: readdata[15:0] = blink_half;
         3'd4: begin
            readdata[0]            = blink_phase;
            readdata[8 +: PWM_BITS] = pwm_cnt;
         end
         3'd5: readdata[LED_WIDTH-1:0] = blink_mask;
         default: readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_nios_system_rleds_pwm.sv
// Directed bench for the red-LED PWM/blink stage.
module tb_nios_system_rleds_pwm;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [17:0] led_in;
   logic [17:0] led_out;

   int tests = 0;
   int fails = 0;

   nios_system_rleds_pwm dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .led_in     (led_in),
      .led_out    (led_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", name, obs, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] e,
                     input string n);
      address    = a;
      chipselect = 1'b0;
      write_n    = 1'b1;
      #1;
      check(n, readdata, e);
   endtask

   task automatic rd_all_reset(input string tag);
      rd(3'd0, 32'd0,      {tag, "_ctrl"});
      rd(3'd1, 32'd255,    {tag, "_duty"});
      rd(3'd2, 32'd0,      {tag, "_pre"});
      rd(3'd3, 32'h00FF,   {tag, "_half"});
      rd(3'd4, 32'd0,      {tag, "_status"});
      rd(3'd5, 32'd0,      {tag, "_mask"});
      rd(3'd6, 32'd0,      {tag, "_a6"});
      rd(3'd7, 32'd0,      {tag, "_a7"});
   endtask

   initial begin
      int on_a, on_b, err, e_led, e_ph, e_cnt;
      logic [17:0] exp_led;
      logic        ph;

      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      led_in     = '0;
      repeat (3) @(negedge clk);
      check("rst_led", {14'd0, led_out}, 32'd0);
      rd_all_reset("rst");
      @(negedge clk);
      reset_n = 1'b1;

      // bypass
      led_in = 18'h2AAAA;
      @(negedge clk);
      check("bypass", {14'd0, led_out}, 32'h2AAAA);

      // duty 64, prescale 0
      led_in = 18'h3FFFF;
      wr(3'd2, 32'd0);
      wr(3'd1, 32'd64);
      wr(3'd0, 32'd1);
      on_a = 0;
      err  = 0;
      for (int i = 1; i <= 256; i++) begin
         @(negedge clk);
         if (led_out == 18'h3FFFF) on_a++;
         if (led_out !== ((i <= 64) ? 18'h3FFFF : 18'h0)) err++;
      end
      check("d64_count", on_a, 64);
      check("d64_shape", err, 0);

      // DUTY write mid-period
      on_a = 0;
      on_b = 0;
      for (int i = 1; i <= 512; i++) begin
         @(negedge clk);
         if (led_out == 18'h3FFFF) begin
            if (i <= 256) on_a++;
            else on_b++;
         end
         if (i == 100) begin
            address    = 3'd1;
            writedata  = 32'd200;
            chipselect = 1'b1;
            write_n    = 1'b0;
         end else if (i == 101) begin
            chipselect = 1'b0;
            write_n    = 1'b1;
         end
      end
      check("d_mid_cur", on_a, 64);
      check("d_mid_next", on_b, 200);
      rd(3'd1, 32'd200, "duty_rb");

      // duty 0 is always off
      wr(3'd0, 32'd0);
      wr(3'd1, 32'd0);
      wr(3'd0, 32'd1);
      on_a = 0;
      for (int i = 1; i <= 256; i++) begin
         @(negedge clk);
         if (led_out != 18'h0) on_a++;
      end
      check("d0_dark", on_a, 0);

      // blink on bit 0, half period 1
      wr(3'd0, 32'd0);
      wr(3'd5, 32'd1);
      wr(3'd3, 32'd1);
      wr(3'd1, 32'd255);
      wr(3'd0, 32'd3);
      address = 3'd4;
      e_led = 0;
      e_ph  = 0;
      e_cnt = 0;
      for (int i = 1; i <= 1024; i++) begin
         @(negedge clk);
         ph = ((i - 1) >= 512);
         exp_led = (((i - 1) % 256) != 255) ? 18'h3FFFF : 18'h0;
         if (ph) exp_led = exp_led & 18'h3FFFE;
         if (led_out !== exp_led) e_led++;
         if (readdata[0] !== ((i >= 512) && (i < 1024))) e_ph++;
         if (32'(readdata[15:8]) != (i % 256)) e_cnt++;
      end
      check("blink_led", e_led, 0);
      check("blink_phase", e_ph, 0);
      check("status_pwm", e_cnt, 0);

      // prescale 3
      wr(3'd0, 32'd0);
      wr(3'd2, 32'd3);
      wr(3'd0, 32'd1);
      address = 3'd4;
      err = 0;
      for (int k = 1; k <= 19; k++) begin
         @(negedge clk);
         if (k <= 16 && 32'(readdata[15:8]) != k / 4) err++;
         if (k == 19) begin
            address    = 3'd2;
            writedata  = 32'd3;
            chipselect = 1'b1;
            write_n    = 1'b0;
         end
      end
      check("pre3_rate", err, 0);
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 3'd4;
      #1;
      check("pre_wr_tick", {24'd0, readdata[15:8]}, 32'd4);
      repeat (3) @(negedge clk);
      check("pre_hold", {24'd0, readdata[15:8]}, 32'd4);
      @(negedge clk);
      check("pre_next", {24'd0, readdata[15:8]}, 32'd5);

      // reset mid-blink
      wr(3'd0, 32'd0);
      wr(3'd2, 32'd0);
      wr(3'd1, 32'd255);
      wr(3'd0, 32'd3);
      repeat (600) @(negedge clk);
      check("pre_rst_led", {14'd0, led_out}, 32'h3FFFE);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst", {14'd0, led_out}, 32'd0);
      rd_all_reset("mid");
      @(negedge clk);
      reset_n = 1'b1;
      led_in  = 18'h15555;
      @(negedge clk);
      check("post_bypass", {14'd0, led_out}, 32'h15555);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
